// File: rtl/controle_ciclo_rega_if.sv
// controle_ciclo_rega_if: irrigation controller signal bundle.
// Carries the decision-logic requests, the tank sensors and operator input
// toward the controller, and the valve drives and status back out.
// master = the side that drives requests/sensors, slave = the controller.
interface controle_ciclo_rega_if;
   logic       gotejamentoReq;
   logic       aspersaoReq;
   logic       erro;
   logic       alarme;
   logic       highLevel;
   logic       clearFault;
   logic       valvulaGotejamento;
   logic       valvulaAspersao;
   logic       valvulaEntrada;
   logic [2:0] estado;
   logic       falha;

   modport master (
      output gotejamentoReq, aspersaoReq, erro, alarme, highLevel, clearFault,
      input  valvulaGotejamento, valvulaAspersao, valvulaEntrada, estado, falha
   );

   modport slave (
      input  gotejamentoReq, aspersaoReq, erro, alarme, highLevel, clearFault,
      output valvulaGotejamento, valvulaAspersao, valvulaEntrada, estado, falha
   );
endinterface

// File: rtl/controle_ciclo_rega.sv
// controle_ciclo_rega: irrigation cycle controller (Moore FSM).
// Runs drip or sprinkler irrigation for TEMPO_REGA cycles, pauses for
// TEMPO_PAUSA cycles, refills the tank on low-level alarm and latches faults.
// Optional macro FILL_TIMEOUT_EN: tank fill that lasts TEMPO_ENCHER cycles
// without reaching the high level is treated as a fault.
module controle_ciclo_rega #(
   parameter int TEMPO_REGA   = 16,
   parameter int TEMPO_PAUSA  = 8,
   parameter int TEMPO_ENCHER = 32
) (
   input logic                   clock,
   input logic                   reset,
   controle_ciclo_rega_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      GOTEJ  = 3'b001,
      ASPER  = 3'b010,
      PAUSA  = 3'b011,
      ENCHER = 3'b100,
      FALHA  = 3'b101
   } stateT;

   // Timed exits fire on the edge where the counter holds T-1, so the state
   // is occupied for exactly T cycles.
   localparam logic [15:0] LAST_REGA  = 16'(TEMPO_REGA - 1);
   localparam logic [15:0] LAST_PAUSA = 16'(TEMPO_PAUSA - 1);
`ifdef FILL_TIMEOUT_EN
   localparam logic [15:0] LAST_ENCHER = 16'(TEMPO_ENCHER - 1);
`endif

   // Reject out-of-range timings at elaboration.
   if (TEMPO_REGA < 1 || TEMPO_REGA > 65535) begin : gBadRega
      $error("TEMPO_REGA out of range 1..65535");
   end
   if (TEMPO_PAUSA < 1 || TEMPO_PAUSA > 65535) begin : gBadPausa
      $error("TEMPO_PAUSA out of range 1..65535");
   end
   if (TEMPO_ENCHER < 1 || TEMPO_ENCHER > 65535) begin : gBadEncher
      $error("TEMPO_ENCHER out of range 1..65535");
   end

   stateT       state;
   stateT       stateNext;
   logic [15:0] cycleCount;

   // State register and in-state cycle counter; counter restarts on every change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cycleCount <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         state <= stateNext;
         if (stateNext != state) cycleCount <= '0;
         else                    cycleCount <= cycleCount + 16'd1;
      end
   end

   // Next-state decision: fault first, then per-state transitions in priority order.
   always_comb begin
      // NOTE: defaulting every combinational output before the branches keeps
      // paths that assign nothing from inferring a latch.
      stateNext = state;
      if (bus.erro && state != FALHA) begin
         stateNext = FALHA;
      end else begin
         case (state)
            IDLE: begin
               if (bus.alarme && !bus.highLevel) stateNext = ENCHER;
               else if (bus.aspersaoReq)         stateNext = ASPER;
               else if (bus.gotejamentoReq)      stateNext = GOTEJ;
            end
            GOTEJ, ASPER: begin
               // Dropping the request does not shorten the run.
               if (bus.alarme)                  stateNext = PAUSA;
               else if (cycleCount == LAST_REGA) stateNext = PAUSA;
            end
            PAUSA: begin
               if (cycleCount == LAST_PAUSA) stateNext = IDLE;
            end
            ENCHER: begin
               if (bus.highLevel) stateNext = IDLE;
`ifdef FILL_TIMEOUT_EN
               else if (cycleCount == LAST_ENCHER) stateNext = FALHA;
`else
               // No watchdog: fill lasts until high level or a sensor fault.
`endif
            end
            FALHA: begin
               if (bus.clearFault && !bus.erro) stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Moore output decode from the state register; valves are mutually exclusive.
   always_comb begin
      bus.valvulaGotejamento = 1'b0;
      bus.valvulaAspersao    = 1'b0;
      bus.valvulaEntrada     = 1'b0;
      bus.falha              = 1'b0;
      bus.estado             = state;
      case (state)
         GOTEJ:   bus.valvulaGotejamento = 1'b1;
         ASPER:   bus.valvulaAspersao    = 1'b1;
         ENCHER:  bus.valvulaEntrada     = 1'b1;
         FALHA:   bus.falha              = 1'b1;
         default: ;
      endcase
   end

endmodule
